pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  16-bit 6502 program counter. Executes one micro-op per cycle: hold, increment,
//  byte-wise vector/absolute load, relative branch. A branch that crosses a page
//  takes one extra fix-up cycle on the high byte. Sits upstream of the 8-bit
//  address-bus registers (ABL/ABH), which take pcl/pch as their D inputs.
// PARAMETERS
//  RESET_PC  16'h0000  PC value on reset; the reset sequencer then loads FFFC/FFFD via LD_LO/LD_HI
// PORTS
//  clk         in   1   system clock, all state changes on rising edge
//  rst         in   1   asynchronous, active-low reset
//  op          in   3   micro-op, sampled each rising edge (encodings below)
//  din         in   8   data bus byte: vector/address byte or signed branch offset
//  pc          out  16  current program counter (registered)
//  pcl         out  8   pc[7:0]
//  pch         out  8   pc[15:8]
//  busy        out  1   high during the page fix-up cycle; op is ignored while high
//  page_cross  out  1   high during the fix-up cycle only (1-cycle pulse per crossing)
// BEHAVIOUR
//  Reset (async, rst=0): pc=RESET_PC, lo_latch=8'h00, state=IDLE, busy=0, page_cross=0.
//   Reset is honoured in any state, including mid fix-up; the pending fix-up is dropped.
//  Op encodings: 000 HOLD, 001 INC, 010 LD_LO, 011 LD_HI, 100 BRANCH, 101-111 reserved = HOLD.
//  All ops are registered: effect visible on pc one edge after sampling, no combinational path op->pc.
//  State IDLE:
//   HOLD   : pc unchanged.
//   INC    : pc <= pc + 1, modulo 2^16 (FFFF -> 0000, no flag).
//   LD_LO  : lo_latch <= din; pc unchanged.
//   LD_HI  : pc <= {din, lo_latch}; lo_latch keeps its value.
//   BRANCH : sum[8:0] = {1'b0,pcl} + {1'b0,din}; pcl <= sum[7:0]; pch unchanged.
//            cross = din[7] ? ~sum[8] : sum[8].
//            cross=1 -> state <= FIXUP, dir <= din[7]; cross=0 -> stay IDLE.
//  State FIXUP (exactly one cycle; busy=1, page_cross=1):
//   pch <= dir ? pch - 1 : pch + 1, modulo 2^8 (00 - 1 -> FF, FF + 1 -> 00).
//   pcl, lo_latch unchanged; op and din ignored; state <= IDLE.
//  busy and page_cross are decoded from the state register only (glitch-free, no op dependency).
//  Offsets 00 and 80 are legal (00 = no move; 80 = -128).
// STRUCTURE
//  Shared package cpu6502_pkg: op encodings (PC_HOLD, PC_INC, PC_LD_LO, PC_LD_HI,
//   PC_BRANCH) and state encodings (PCS_IDLE, PCS_FIXUP); this block imports them,
//   and the microcode sequencer uses the same constants.
//  Single module, no sub-modules. Registers: pc[15:0], lo_latch[7:0], state, dir.
// TESTING
//  1. rst low mid-run, then high -> pc=0000, busy=0, page_cross=0 asynchronously; LD_LO FC, LD_HI FF -> pc=FFFC.
//  2. pc=FFFF, INC -> pc=0000; INC x3 from 12FE -> 12FF, 1300, 1301.
//  3. pc=1220, BRANCH din=10 -> pc=1230, busy never asserted; BRANCH din=F0 -> pc=1220.
//  4. pc=12F0, BRANCH din=20 -> pc=1210, busy=1, page_cross=1 for one cycle -> pc=1310;
//     INC on op during the FIXUP cycle ignored.
//  5. pc=1205, BRANCH din=80 -> pc=1285 then FIXUP -> pc=1185; pc=0010, BRANCH din=E0 -> 00F0 -> FFF0.
//  6. pc=12F0, BRANCH din=20, rst asserted during FIXUP -> pc=RESET_PC, busy=0, no late pch update after release.

Source files
------------

// File: rtl/cpu6502_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu6502_pkg
//  Description : Shared constants for the 6502 core. This package holds the
//                program-counter micro-op encodings and the PC state
//                encodings. The PC unit and the microcode sequencer both use
//                them, so the two blocks always agree on the op field.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu6502_pkg;

    // Program-counter micro-ops. Codes 3'b101..3'b111 are reserved and
    // behave as PC_HOLD.
    localparam logic [2:0] PC_HOLD   = 3'b000;
    localparam logic [2:0] PC_INC    = 3'b001;
    localparam logic [2:0] PC_LD_LO  = 3'b010;
    localparam logic [2:0] PC_LD_HI  = 3'b011;
    localparam logic [2:0] PC_BRANCH = 3'b100;

    // PC unit state. FIXUP is the single extra cycle that a page-crossing
    // branch spends correcting the high byte.
    typedef enum logic [0:0] {
        PCS_IDLE  = 1'b0,
        PCS_FIXUP = 1'b1
    } pc_state_t;

    // A branch adds the offset to the low byte only. The offset is signed,
    // so the carry out of the 8-bit add means different things:
    //   forward offset  (bit 7 = 0): a carry means we ran past xxFF.
    //   backward offset (bit 7 = 1): no carry means we borrowed below xx00.
    function automatic logic branch_crosses(input logic carry, input logic offset_neg);
        return offset_neg ? ~carry : carry;
    endfunction

endpackage : cpu6502_pkg
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : 16-bit 6502 program counter. It runs one micro-op per clock:
//                hold, increment, byte-wise load (low byte latched, then the
//                high byte commits both), and relative branch. When a branch
//                crosses a page, the unit adds one fix-up cycle that corrects
//                the high byte. The outputs feed the ABL/ABH address
//                registers.
//  Revision    : 1.0 - initial release
//
//  Parameters
//    RESET_PC    PC value loaded while reset is asserted
//
//  Ports
//    clk         system clock, rising edge
//    rst         asynchronous active-low reset
//    op[2:0]     micro-op (cpu6502_pkg PC_* encodings)
//    din[7:0]    data byte: vector/address byte or signed branch offset
//    pc[15:0]    registered program counter
//    pcl[7:0]    pc[7:0]
//    pch[7:0]    pc[15:8]
//    busy        high during the fix-up cycle; op is ignored then
//    page_cross  one-cycle pulse during the fix-up cycle
// ============================================================================
module pc_unit
    import cpu6502_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op,
    input  logic [7:0]  din,
    output logic [15:0] pc,
    output logic [7:0]  pcl,
    output logic [7:0]  pch,
    output logic        busy,
    output logic        page_cross
);

    logic [15:0] r_pc;
    logic [7:0]  r_lo_latch;
    pc_state_t   r_state;
    logic        r_dir;         // 1: the branch went backward, so decrement pch

    logic [8:0]  w_sum;
    logic        w_cross;

    // The low-byte add is unsigned. The carry together with the sign of the
    // offset tells us whether the target lies on a different page.
    assign w_sum   = {1'b0, r_pc[7:0]} + {1'b0, din};
    assign w_cross = branch_crosses(w_sum[8], din[7]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_lo_latch <= 8'h00;
            r_state    <= PCS_IDLE;
            r_dir      <= 1'b0;
        end else if (r_state == PCS_FIXUP) begin
            // Only the high byte moves. op and din are ignored this cycle.
            r_pc[15:8] <= r_dir ? (r_pc[15:8] - 8'd1) : (r_pc[15:8] + 8'd1);
            r_state    <= PCS_IDLE;
        end else begin
            case (op)
                PC_INC: begin
                    r_pc <= r_pc + 16'd1;
                end
                PC_LD_LO: begin
                    r_lo_latch <= din;
                end
                PC_LD_HI: begin
                    r_pc <= {din, r_lo_latch};
                end
                PC_BRANCH: begin
                    r_pc[7:0] <= w_sum[7:0];
                    if (w_cross) begin
                        r_state <= PCS_FIXUP;
                        r_dir   <= din[7];
                    end
                end
                default: begin
                    // PC_HOLD and the reserved codes keep the PC unchanged.
                end
            endcase
        end
    end

    assign pc         = r_pc;
    assign pcl        = r_pc[7:0];
    assign pch        = r_pc[15:8];
    // Both flags come only from the state flop, so they do not depend on op.
    assign busy       = (r_state == PCS_FIXUP);
    assign page_cross = (r_state == PCS_FIXUP);

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Scoreboard bench for pc_unit. The driver issues one
//                micro-op per cycle and queues the expected post-edge state.
//                A monitor pops one entry each falling edge and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;
    import cpu6502_pkg::*;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        busy;
        logic        pcross;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  op  = PC_HOLD;
    logic [7:0]  din = 8'h00;
    logic [15:0] pc;
    logic [7:0]  pcl;
    logic [7:0]  pch;
    logic        busy;
    logic        page_cross;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    logic [15:0] cur_pc = 16'h0000;   // last expected PC, used by helpers

    pc_unit #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .din        (din),
        .pc         (pc),
        .pcl        (pcl),
        .pch        (pch),
        .busy       (busy),
        .page_cross (page_cross)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] e_pc,
                         input logic e_busy, input logic e_pcross);
        n_checks++;
        if (pc !== e_pc || pcl !== e_pc[7:0] || pch !== e_pc[15:8] ||
            busy !== e_busy || page_cross !== e_pcross) begin
            n_fail++;
            $display("FAIL %s: got pc=%h pcl=%h pch=%h busy=%b page_cross=%b, expected pc=%h busy=%b page_cross=%b",
                     name, pc, pcl, pch, busy, page_cross, e_pc, e_busy, e_pcross);
        end
    endtask

    // Monitor: outputs are stable at the falling edge. One entry is consumed
    // per cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.name, e.pc, e.busy, e.pcross);
        end
    end

    // Drive one op just after a falling edge. Then queue the state expected
    // after the following rising edge.
    task automatic step(input string name, input logic [2:0] o, input logic [7:0] d,
                        input logic [15:0] e_pc, input logic e_busy, input logic e_pcross);
        exp_t e;
        @(negedge clk);
        #1;
        op  = o;
        din = d;
        e.name = name; e.pc = e_pc; e.busy = e_busy; e.pcross = e_pcross;
        sb_q.push_back(e);
        cur_pc = e_pc;
    endtask

    task automatic load(input string name, input logic [15:0] addr);
        step({name, "_lo"}, PC_LD_LO, addr[7:0], cur_pc, 1'b0, 1'b0);
        step({name, "_hi"}, PC_LD_HI, addr[15:8], addr, 1'b0, 1'b0);
    endtask

    // Wait (bounded) until the monitor has consumed every queued entry.
    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() > 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb_q.size());
            sb_q.delete();
        end
        op  = PC_HOLD;
        din = 8'h00;
    endtask

    initial begin
        // Power-on reset.
        #7;
        check("por", 16'h0000, 1'b0, 1'b0);
        @(negedge clk); #3 rst = 1'b1;

        // 1. Load a vector, run a little, reset mid-run, then reload FFFC.
        load("vec_a", 16'hABCD);
        step("inc_a", PC_INC, 8'h00, 16'hABCE, 1'b0, 1'b0);
        drain();
        #2 rst = 1'b0;
        #1 check("async_rst", 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1 check("rst_held", 16'h0000, 1'b0, 1'b0);
        @(negedge clk); #3 rst = 1'b1;
        cur_pc = 16'h0000;
        load("vec_fffc", 16'hFFFC);
        // lo_latch is kept, so a second LD_HI reuses FC.
        step("ld_hi_reuse", PC_LD_HI, 8'h12, 16'h12FC, 1'b0, 1'b0);
        step("reserved_101", 3'b101, 8'h55, 16'h12FC, 1'b0, 1'b0);
        step("reserved_111", 3'b111, 8'h55, 16'h12FC, 1'b0, 1'b0);

        // 2. Increment wrap and page carry.
        load("set_ffff", 16'hFFFF);
        step("inc_wrap", PC_INC, 8'h00, 16'h0000, 1'b0, 1'b0);
        load("set_12fe", 16'h12FE);
        step("inc_1", PC_INC, 8'h00, 16'h12FF, 1'b0, 1'b0);
        step("inc_2", PC_INC, 8'h00, 16'h1300, 1'b0, 1'b0);
        step("inc_3", PC_INC, 8'h00, 16'h1301, 1'b0, 1'b0);

        // 3. Branches that stay on the same page.
        load("set_1220", 16'h1220);
        step("br_fwd_10", PC_BRANCH, 8'h10, 16'h1230, 1'b0, 1'b0);
        step("br_back_f0", PC_BRANCH, 8'hF0, 16'h1220, 1'b0, 1'b0);
        step("br_zero", PC_BRANCH, 8'h00, 16'h1220, 1'b0, 1'b0);
        step("hold_after_br", PC_HOLD, 8'h00, 16'h1220, 1'b0, 1'b0);

        // 4. Forward crossing; INC during the fix-up cycle is ignored.
        load("set_12f0", 16'h12F0);
        step("br_fwd_cross", PC_BRANCH, 8'h20, 16'h1210, 1'b1, 1'b1);
        step("fixup_fwd", PC_INC, 8'h00, 16'h1310, 1'b0, 1'b0);
        step("post_fixup", PC_HOLD, 8'h00, 16'h1310, 1'b0, 1'b0);

        // 5. Backward crossings, including the -128 offset and a pch wrap.
        load("set_1205", 16'h1205);
        step("br_m128", PC_BRANCH, 8'h80, 16'h1285, 1'b1, 1'b1);
        step("fixup_m128", PC_HOLD, 8'h00, 16'h1185, 1'b0, 1'b0);
        load("set_0010", 16'h0010);
        step("br_back_e0", PC_BRANCH, 8'hE0, 16'h00F0, 1'b1, 1'b1);
        step("fixup_wrap", PC_BRANCH, 8'h10, 16'hFFF0, 1'b0, 1'b0);
        // Forward crossing from page FF wraps pch to 00.
        load("set_fff0", 16'hFFF0);
        step("br_ff_cross", PC_BRANCH, 8'h20, 16'hFF10, 1'b1, 1'b1);
        step("fixup_ff00", PC_HOLD, 8'h00, 16'h0010, 1'b0, 1'b0);

        // 6. Reset during FIXUP drops the pending high-byte update.
        load("set_12f0_b", 16'h12F0);
        step("br_cross_rst", PC_BRANCH, 8'h20, 16'h1210, 1'b1, 1'b1);
        drain();
        #2 rst = 1'b0;
        #1 check("rst_in_fixup", 16'h0000, 1'b0, 1'b0);
        @(negedge clk); #3 rst = 1'b1;
        cur_pc = 16'h0000;
        step("no_late_fixup", PC_HOLD, 8'h00, 16'h0000, 1'b0, 1'b0);
        step("no_late_fixup2", PC_HOLD, 8'h00, 16'h0000, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

endmodule : tb_pc_unit
`default_nettype wire
